// File: rtl/div_share_ctrl.sv
// div_share_ctrl: arbitrates one iterative signed divider among N requesters.
// A request is granted round-robin and the divider is held enabled until it
// reports done. The quotient is then returned tagged with the requester id.
// A zero divisor is answered locally with a saturated quotient. A divider that
// hangs is aborted after TIMEOUT busy cycles.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_req_valid/i_req_a/i_req_b   packed per-requester operands (k at [k*DATA_W +: DATA_W])
//   o_req_ready                   one-hot accept pulse (combinational, IDLE only)
//   o_rsp_valid/id/data/err       response, held until i_rsp_ready
//   o_div_en/o_div_a/o_div_b      divider drive, enable high for all of BUSY
//   i_div_fin/i_div_result        divider completion and quotient
//   o_busy                        controller not idle
module div_share_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N-1:0]          i_req_valid,
  input  logic [N*DATA_W-1:0]   i_req_a,
  input  logic [N*DATA_W-1:0]   i_req_b,
  output logic [N-1:0]          o_req_ready,
  output logic                  o_rsp_valid,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [DATA_W-1:0]     o_rsp_data,
  output logic                  o_rsp_err,
  input  logic                  i_rsp_ready,
  output logic                  o_div_en,
  output logic [DATA_W-1:0]     o_div_a,
  output logic [DATA_W-1:0]     o_div_b,
  input  logic                  i_div_fin,
  input  logic [DATA_W-1:0]     i_div_result,
  output logic                  o_busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] POS_SAT  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_SAT  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, div_en_q, busy_q;

  // Round-robin winner search starting at rr_ptr
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  int unsigned         idx;
  logic [DATA_W-1:0]   win_a, win_b;
  logic                grant;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!win_found && i_req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  assign win_a = i_req_a[32'(win_id) * DATA_W +: DATA_W];
  assign win_b = i_req_b[32'(win_id) * DATA_W +: DATA_W];

  // A grant taken during reset would be discarded, so do not advertise it
  assign grant       = (state_q == S_IDLE) && win_found && !i_rst;
  assign o_req_ready = grant ? (N'(1) << win_id) : '0;

  // Next-state and datapath latch logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    data_d   = data_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          a_d  = win_a;
          b_d  = win_b;
          id_d = win_id;
          if (win_b == '0) begin
            // Zero divisor: answer with a saturated quotient, divider untouched
            data_d  = win_a[DATA_W-1] ? NEG_SAT : POS_SAT;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_div_fin) begin
          data_d  = i_div_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          rr_ptr_d = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; flags are decoded from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      div_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      data_q      <= data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= (state_d == S_RESP);
      div_en_q    <= (state_d == S_BUSY);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = id_q;
  assign o_rsp_data  = data_q;
  assign o_rsp_err   = err_q;
  assign o_div_en    = div_en_q;
  assign o_div_a     = a_q;
  assign o_div_b     = b_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Testbench for div_share_ctrl: behavioural divider plus a transaction-level
// reference for arbitration order, quotient, error flag and latency.
module tb_div_share_ctrl;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int IDW   = 2;
  localparam int TMO   = 64;
  localparam int BOUND = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N*DW-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            rsp_ready;
  logic            div_en;
  logic [DW-1:0]   div_a, div_b;
  logic            div_fin;
  logic [DW-1:0]   div_result;
  logic            busy;

  logic [DW-1:0]   a_arr [N];
  logic [DW-1:0]   b_arr [N];

  int fin_at    = 7;
  logic stale_fin = 1'b0;
  int dcnt      = 0;
  int en_cycles = 0;
  int exp_ptr   = 0;
  int total     = 0;
  int passed    = 0;

  always #5 clk = ~clk;

  div_share_ctrl #(.N(N), .DATA_W(DW), .ID_W(IDW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_a(req_a), .i_req_b(req_b),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .i_rsp_ready(rsp_ready),
    .o_div_en(div_en), .o_div_a(div_a), .o_div_b(div_b), .i_div_fin(div_fin),
    .i_div_result(div_result), .o_busy(busy)
  );

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_a[k*DW +: DW] = a_arr[k];
      req_b[k*DW +: DW] = b_arr[k];
    end
  end

  function automatic logic [DW-1:0] model_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int q;
    if (b == '0) return '0;
    q = (int'($signed(a)) * 256) / int'($signed(b));
    return DW'(q);
  endfunction

  // Divider model: fin in the fin_at-th cycle of a continuous enable run (0 = never)
  always @(posedge clk) begin
    if (div_en) begin
      dcnt      <= dcnt + 1;
      en_cycles <= en_cycles + 1;
    end else begin
      dcnt <= 0;
    end
  end
  assign div_fin    = (fin_at != 0 && div_en && dcnt == fin_at - 1) || stale_fin;
  assign div_result = model_div(div_a, div_b);

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_nz();
    logic [DW-1:0] x;
    do x = DW'($urandom); while (x == '0);
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst   = 1'b1;
    valid = '0;
    tick();
    tick();
    rst     = 1'b0;
    exp_ptr = 0;
    #1;
  endtask

  // Wait for the grant, then the response; compare everything with the reference
  task automatic serve(input string tag, output int id, output logic [DW-1:0] ed, output logic ee);
    int lat, el;
    logic [DW-1:0] ea, eb;
    #1;
    id  = pick(valid, exp_ptr);
    ed  = '0;
    ee  = 1'b0;
    lat = 0;
    while (req_ready == '0 && lat < BOUND) begin tick(); lat++; end
    check({tag, "/grant"}, 32'(req_ready), (id < 0) ? 32'd0 : 32'(1 << id));
    if (id < 0) return;
    check({tag, "/en_gap"}, 32'(div_en), 32'd0);
    ea = a_arr[id];
    eb = b_arr[id];
    if (eb == '0) begin
      ed = ($signed(ea) < 0) ? 16'h8000 : 16'h7FFF; ee = 1'b1; el = 1;
    end else if (fin_at == 0) begin
      ed = '0; ee = 1'b1; el = TMO + 1;
    end else begin
      ed = model_div(ea, eb); ee = 1'b0; el = fin_at + 1;
    end
    tick();
    check({tag, "/one_shot"}, 32'(req_ready), 32'd0);
    if (eb != '0) begin
      check({tag, "/div_en"}, 32'(div_en), 32'd1);
      check({tag, "/div_a"}, 32'(div_a), 32'(ea));
      check({tag, "/div_b"}, 32'(div_b), 32'(eb));
    end
    lat = 1;
    while (!rsp_valid && lat < BOUND) begin tick(); lat++; end
    check({tag, "/latency"}, 32'(lat), 32'(el));
    check({tag, "/rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, "/rsp_data"}, 32'(rsp_data), 32'(ed));
    check({tag, "/rsp_err"}, 32'(rsp_err), 32'(ee));
    if (rsp_ready) exp_ptr = (id + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, en0;
    logic [DW-1:0] ed;
    logic ee;

    rsp_ready = 1'b1;
    valid     = '0;
    for (int k = 0; k < N; k++) begin a_arr[k] = '0; b_arr[k] = '0; end

    // Reset state
    reset_dut();
    check("rst/busy", 32'(busy), 0);
    check("rst/rsp_valid", 32'(rsp_valid), 0);
    check("rst/div_en", 32'(div_en), 0);
    check("rst/req_ready", 32'(req_ready), 0);
    check("rst/rsp_data", 32'(rsp_data), 0);
    check("rst/div_a", 32'(div_a), 0);

    // 1: single request, -5066/10028 scaled by 256
    a_arr[0] = 16'hEC36;
    b_arr[0] = 16'h272C;
    valid    = 4'b0001;
    serve("t1", id, ed, ee);
    check("t1/lit_data", 32'(rsp_data), 32'h0000FF7F);
    valid = '0;
    tick();
    check("t1/rsp_done", 32'(rsp_valid), 0);

    // 2: all four requesters, random operands, round-robin order
    reset_dut();
    for (int k = 0; k < N; k++) begin a_arr[k] = DW'($urandom); b_arr[k] = rand_nz(); end
    valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      serve("t2", id, ed, ee);
      if (g == 0) begin
        a_arr[0] = DW'($urandom);
        b_arr[0] = rand_nz();
      end else if (id >= 0) begin
        valid[id] = 1'b0;
      end
    end
    check("t2/all_served", 32'(valid), 0);

    // 3: zero divisor, negative and positive numerator
    tick();
    en0      = en_cycles;
    a_arr[2] = 16'hFFF9;
    b_arr[2] = '0;
    valid    = 4'b0100;
    serve("t3neg", id, ed, ee);
    check("t3neg/lit", 32'(rsp_data), 32'h00008000);
    valid = '0;
    tick();
    a_arr[2] = 16'd5;
    valid    = 4'b0100;
    serve("t3pos", id, ed, ee);
    check("t3pos/lit", 32'(rsp_data), 32'h00007FFF);
    valid = '0;
    tick();
    check("t3/no_div_en", 32'(en_cycles - en0), 0);

    // 4: divider hangs -> timeout; then fin exactly on the last allowed cycle
    fin_at   = 0;
    a_arr[3] = DW'($urandom);
    b_arr[3] = rand_nz();
    valid    = 4'b1000;
    serve("t4tmo", id, ed, ee);
    valid = '0;
    tick();
    fin_at   = TMO;
    a_arr[3] = DW'($urandom);
    b_arr[3] = rand_nz();
    valid    = 4'b1000;
    serve("t4edge", id, ed, ee);
    valid  = '0;
    fin_at = 7;
    tick();

    // 5: response backpressure for 20 cycles
    rsp_ready = 1'b0;
    for (int k = 0; k < N; k++) begin a_arr[k] = DW'($urandom); b_arr[k] = rand_nz(); end
    valid = 4'b1010;
    serve("t5", id, ed, ee);
    if (id >= 0) valid[id] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t5/hold_valid", 32'(rsp_valid), 1);
      check("t5/hold_id", 32'(rsp_id), 32'(id));
      check("t5/hold_data", 32'(rsp_data), 32'(ed));
      check("t5/no_grant", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    exp_ptr   = (id + 1) % N;
    serve("t5next", id, ed, ee);
    valid = '0;
    tick();

    // 6: reset in the middle of BUSY, stale fin afterwards
    a_arr[2] = DW'($urandom);
    b_arr[2] = rand_nz();
    valid    = 4'b0100;
    #1;
    check("t6/grant", 32'(req_ready), 32'b0100);
    tick();
    valid = '0;
    tick();
    tick();
    check("t6/busy_before", 32'(div_en), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6/busy", 32'(busy), 0);
    check("t6/div_en", 32'(div_en), 0);
    check("t6/rsp_valid", 32'(rsp_valid), 0);
    check("t6/div_a", 32'(div_a), 0);
    check("t6/div_b", 32'(div_b), 0);
    check("t6/rsp_err", 32'(rsp_err), 0);
    stale_fin = 1'b1;
    tick();
    stale_fin = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6/no_rsp", 32'(rsp_valid), 0);
      check("t6/idle", 32'(busy), 0);
    end
    exp_ptr  = 0;
    a_arr[1] = DW'($urandom);
    b_arr[1] = rand_nz();
    a_arr[3] = DW'($urandom);
    b_arr[3] = rand_nz();
    valid    = 4'b1010;
    serve("t6next", id, ed, ee);
    valid = '0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
